// File: rtl/signedmul_arbiter.sv
// signedmul_arbiter: round-robin sequencer sharing one combinational multiplier among NUM_REQ requesters.
// Defining SIGNEDMUL_ARB_PERF_EN adds per-requester 16-bit grant counters (grant_cnt, cnt_clr).
module signedmul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    input  logic [DATA_W-1:0]         mul_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
`ifdef SIGNEDMUL_ARB_PERF_EN
    input  logic                      cnt_clr,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
    output logic                      busy
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ID_W-1:0]    w_gnt;
    logic               w_gnt_vld;
    logic               w_fire;
    // Scan from farthest to nearest so the nearest valid requester after r_rr_ptr wins.
    always_comb begin
        int j;
        j = 0;
        w_gnt_vld = 1'b0;
        w_gnt = r_rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[j[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt = j[ID_W-1:0];
            end
        end
    end
    assign w_fire    = rst_n & (r_state == IDLE) & w_gnt_vld;
    assign req_ready = w_fire ? (NUM_REQ'(1) << w_gnt) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_fire) begin
                    r_mul_a  <= req_a[w_gnt*DATA_W +: DATA_W];
                    r_mul_b  <= req_b[w_gnt*DATA_W +: DATA_W];
                    r_rsp_id <= w_gnt;
                    r_rr_ptr <= w_gnt;
                    r_cnt    <= CNT_W'(MUL_LAT - 1);
                    r_state  <= WAIT;
                end
                WAIT: if (r_cnt == '0) begin
                    r_rsp_data  <= mul_c;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_state != IDLE;
`ifdef SIGNEDMUL_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] r_gcnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                          r_gcnt <= '0;
            else if (cnt_clr)                    r_gcnt <= '0;
            else if (req_valid[g] & req_ready[g]) r_gcnt <= r_gcnt + 16'd1;
        end
        assign grant_cnt[g*16 +: 16] = r_gcnt;
    end
`endif
endmodule

// File: tb/tb_signedmul_arbiter.sv
// tb_signedmul_arbiter: table-driven and hand-sequenced checks with a response scoreboard.
module tb_signedmul_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [15:0] mul_a, mul_b, mul_c, rsp_data;
    logic        rsp_valid, busy;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
`ifdef SIGNEDMUL_ARB_PERF_EN
    logic        cnt_clr = 1'b0;
    logic [63:0] grant_cnt;
`endif

    always #5 clk = ~clk;
    assign mul_c = mul_a ^ mul_b;

    signedmul_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef SIGNEDMUL_ARB_PERF_EN
        .cnt_clr(cnt_clr), .grant_cnt(grant_cnt),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  id;
        logic [15:0] data;
    } vec_t;
    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          t;
        int          lat;
    } exp_t;

    localparam logic [63:0] A = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    localparam logic [63:0] B = {16'hFFFF, 16'h0001, 16'h00FF, 16'hABCD};

    exp_t exp_q[$];
    exp_t e_pop;
    vec_t tbl[12];
    vec_t v_one;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e_pop = exp_q.pop_front();
                chk("rsp_id", rsp_id, e_pop.id);
                chk("rsp_data", rsp_data, e_pop.data);
                if (e_pop.lat != 0) chk("rsp_latency", cyc - e_pop.t, e_pop.lat);
            end
        end
    end

    task automatic wait_grant();
        int n = 0;
        @(negedge clk);
        while (req_ready == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        req_valid = v.valid;
        req_a = v.a;
        req_b = v.b;
        wait_grant();
        chk("grant", req_ready, 32'(4'b0001 << v.id));
        chk("busy_grant", busy, 0);
        exp_q.push_back('{v.id, v.data, cyc, 3});
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("busy_wait", busy, 1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0001, 64'h1234, 64'h00FF, 2'd0, 16'h12CB};
        tbl[1]  = '{4'b1111, A, B, 2'd1, 16'hFF00};
        tbl[2]  = '{4'b1111, A, B, 2'd2, 16'h7FFE};
        tbl[3]  = '{4'b1111, A, B, 2'd3, 16'h7FFF};
        tbl[4]  = '{4'b0110, A, B, 2'd1, 16'hFF00};
        tbl[5]  = '{4'b0110, A, B, 2'd2, 16'h7FFE};
        tbl[6]  = '{4'b0110, A, B, 2'd1, 16'hFF00};
        tbl[7]  = '{4'b1000, A, B, 2'd3, 16'h7FFF};
        tbl[8]  = '{4'b1000, A, B, 2'd3, 16'h7FFF};
        tbl[9]  = '{4'b1001, A, B, 2'd0, 16'hABCD};
        tbl[10] = '{4'b1001, A, B, 2'd3, 16'h7FFF};
        tbl[11] = '{4'b0101, A, B, 2'd0, 16'hABCD};

        #1;
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All four requesters held valid: grants must rotate from requester 0.
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        req_a = {16'd3, 16'd2, 16'd1, 16'd0};
        req_b = {4{16'h0100}};
        for (int k = 0; k < 6; k++) begin
            wait_grant();
            chk("fair_grant", req_ready, 32'(4'b0001 << (k % 4)));
            if (k > 0) chk("fair_spacing", cyc - last, 4);
            last = cyc;
            exp_q.push_back('{2'(k % 4), 16'h0100 + 16'(k % 4), cyc, 3});
        end
        @(posedge clk);
        #1 req_valid = '0;
        drain();

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // No requesters: stay idle, pointer unchanged (last grant was 0, so 1 goes next).
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", req_ready, 0);
            chk("idle_busy", busy, 0);
        end
        v_one = '{4'b1111, A, B, 2'd1, 16'hFF00};
        run_vec(v_one);

        // Backpressure: response held, others not acknowledged, next grant right after accept.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        wait_grant();
        chk("bp_grant", req_ready, 32'b0100);
        exp_q.push_back('{2'd2, 16'h7FFE, cyc, 0});
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data", rsp_data, 16'h7FFE);
            chk("bp_hold_id", rsp_id, 2);
            chk("bp_no_grant", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", req_ready, 32'b1000);
        exp_q.push_back('{2'd3, 16'h7FFF, cyc, 3});
        @(posedge clk);
        #1 req_valid = '0;
        drain();

        // Reset during WAIT: operation dropped, outputs cleared at once, req0 first after release.
        @(posedge clk);
        #1 req_valid = 4'hF;
        wait_grant();
        chk("mid_grant", req_ready, 32'b0001);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_mul_a", mul_a, 0);
        chk("mid_mul_b", mul_b, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_busy", busy, 0);
        chk("mid_req_ready", req_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_hold_valid", rsp_valid, 0);
            chk("mid_hold_ready", req_ready, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", req_ready, 32'b0001);
        exp_q.push_back('{2'd0, 16'hABCD, cyc, 3});
        @(posedge clk);
        #1 req_valid = '0;
        drain();

`ifdef SIGNEDMUL_ARB_PERF_EN
        v_one = '{4'b0100, A, B, 2'd2, 16'h7FFE};
        repeat (3) run_vec(v_one);
        chk("perf_cnt2", grant_cnt[47:32], 3);
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        cnt_clr = 1'b1;
        wait_grant();
        chk("perf_clr_grant", req_ready, 32'b0100);
        exp_q.push_back('{2'd2, 16'h7FFE, cyc, 3});
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        req_valid = '0;
        chk("perf_cleared", grant_cnt[47:32], 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
